// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side serializer.
// Optional read-timeout watchdog is enabled by defining FIFO_RD_TIMEOUT_EN.
package fifo_rd_pkg;

    localparam int unsigned FIFO_DW = 64;
    localparam int unsigned USEDW_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        SEND
    } rd_state_t;

    // Returns the word shifted so that beat `idx` (in emission order) sits at bit 0.
    function automatic logic [FIFO_DW-1:0] beat_sel(input logic [FIFO_DW-1:0] word,
                                                    input int unsigned idx,
                                                    input logic msb_first,
                                                    input int unsigned beat_w);
        int unsigned beats;
        int unsigned pos;
        beats = FIFO_DW / beat_w;
        pos   = msb_first ? (beats - 1 - idx) : idx;
        return word >> (pos * beat_w);
    endfunction

endpackage

// File: rtl/fifo_rd_watchdog.sv
// WAIT-state timeout counter for the FIFO read serializer.
// Present only when FIFO_RD_TIMEOUT_EN is defined.
`ifdef FIFO_RD_TIMEOUT_EN
module fifo_rd_watchdog #(
    parameter int unsigned RD_TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic expired
);

    localparam int unsigned CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts consecutive active cycles; restarts whenever the FSM leaves WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!active) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = active && (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/fifo_rd_serializer.sv
// Drains 64-bit FIFO words one read at a time and emits each as OUT_W-bit valid/ready beats.
// Define FIFO_RD_TIMEOUT_EN to add the rd_err_o port and a bounded wait for rvalid.
module fifo_rd_serializer
    import fifo_rd_pkg::*;
#(
    parameter int unsigned OUT_W      = 16,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned RD_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               fifo_read_o,
    input  logic [FIFO_DW-1:0] fifo_rdata_i,
    input  logic               fifo_rvalid_i,
    input  logic [USEDW_W-1:0] fifo_usedw_i,
    output logic [OUT_W-1:0]   dout_o,
    output logic               dvalid_o,
    input  logic               dready_i,
    output logic               dlast_o,
    output logic               busy_o,
`ifdef FIFO_RD_TIMEOUT_EN
    output logic               rd_err_o,
`endif
    output logic [31:0]        words_cnt_o
);

    localparam int unsigned BEATS = FIFO_DW / OUT_W;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    if ((OUT_W == 0) || ((FIFO_DW % OUT_W) != 0)) begin : g_bad_out_w
        $error("OUT_W must divide FIFO_DW");
    end
    if (RD_TIMEOUT == 0) begin : g_bad_timeout
        $error("RD_TIMEOUT must be non-zero");
    end

    rd_state_t          state_q;
    logic [FIFO_DW-1:0] word_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        words_q;
    logic [FIFO_DW-1:0] beat_word;
    logic               fifo_avail;
    logic               timeout;

    assign fifo_avail = (fifo_usedw_i != '0);

`ifdef FIFO_RD_TIMEOUT_EN
    logic rd_err_q;

    fifo_rd_watchdog #(
        .RD_TIMEOUT(RD_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .active (state_q == WAIT),
        .expired(timeout)
    );

    assign rd_err_o = rd_err_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            idx_q    <= '0;
            words_q  <= '0;
`ifdef FIFO_RD_TIMEOUT_EN
            rd_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_avail) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // rvalid wins over a simultaneous expiry so an on-time word is never lost.
                    if (fifo_rvalid_i) begin
                        word_q  <= fifo_rdata_i;
                        idx_q   <= '0;
                        state_q <= SEND;
                    end else if (timeout) begin
                        state_q  <= IDLE;
`ifdef FIFO_RD_TIMEOUT_EN
                        rd_err_q <= 1'b1;
`endif
                    end
                end
                SEND: begin
                    if (dready_i) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            words_q <= words_q + 32'd1;
                            state_q <= fifo_avail ? REQ : IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign beat_word = beat_sel(word_q, 32'(idx_q), MSB_FIRST, OUT_W);

    if (OUT_W < FIFO_DW) begin : g_beat_hi
        logic unused_beat_hi;
        assign unused_beat_hi = ^beat_word[FIFO_DW-1:OUT_W];
    end

    assign fifo_read_o = (state_q == REQ);
    assign dvalid_o    = (state_q == SEND);
    assign busy_o      = (state_q != IDLE);
    assign dlast_o     = (state_q == SEND) && (idx_q == LAST_IDX);
    assign dout_o      = beat_word[OUT_W-1:0];
    assign words_cnt_o = words_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Randomized self-checking bench for fifo_rd_serializer with a queue-based FIFO/sink model.
// Timeout scenario is exercised only when FIFO_RD_TIMEOUT_EN is defined.
module tb_fifo_rd_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_read_o;
    logic [63:0] fifo_rdata_i;
    logic        fifo_rvalid_i;
    logic [7:0]  fifo_usedw_i;
    logic [15:0] dout_o;
    logic        dvalid_o;
    logic        dready_i;
    logic        dlast_o;
    logic        busy_o;
    logic [31:0] words_cnt_o;
`ifdef FIFO_RD_TIMEOUT_EN
    logic        rd_err_o;
`endif

    always #5 clk = ~clk;

    fifo_rd_serializer #(
        .OUT_W     (16),
        .MSB_FIRST (1'b1),
        .RD_TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_read_o  (fifo_read_o),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rvalid_i(fifo_rvalid_i),
        .fifo_usedw_i (fifo_usedw_i),
        .dout_o       (dout_o),
        .dvalid_o     (dvalid_o),
        .dready_i     (dready_i),
        .dlast_o      (dlast_o),
        .busy_o       (busy_o),
`ifdef FIFO_RD_TIMEOUT_EN
        .rd_err_o     (rd_err_o),
`endif
        .words_cnt_o  (words_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: FIFO contents, words read but not yet delivered, pending rvalid.
    logic [63:0] fifo_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] pend_word;
    int          pend_cd  = -1;
    int          rv_delay = 0;
    bit          stray_en = 0;
    int          rdy_mode = 0;
    bit          rdy_pat[$];

    logic [63:0] acc;
    int          nb;
    int          exp_words;
    int          cyc;
    int          xfer_cnt;
    int          dv_cycles;
    logic [15:0] beats_seen[$];
    int          xfer_cyc[$];

    bit          prev_stall, prev_rvalid, prev_last_req, prev_done;
    logic [15:0] prev_dout;

    logic        s_rd, s_dv, s_dl, s_by, s_err;
    logic [15:0] s_d;
    logic [31:0] s_wc;

    function automatic void model_clear();
        fifo_q.delete();
        exp_q.delete();
        rdy_pat.delete();
        pend_cd       = -1;
        acc           = '0;
        nb            = 0;
        exp_words     = 0;
        prev_stall    = 0;
        prev_rvalid   = 0;
        prev_last_req = 0;
        prev_done     = 0;
        fifo_usedw_i  = '0;
        fifo_rvalid_i = 1'b0;
        fifo_rdata_i  = '0;
        dready_i      = 1'b0;
    endfunction

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock of the environment: sample at negedge, check, then drive next inputs.
    task automatic step();
        logic        rv, rdy, stray, xfer, had_pend;
        logic [63:0] rv_data, w;
        @(negedge clk);
        cyc++;
        s_rd = fifo_read_o;
        s_dv = dvalid_o;
        s_d  = dout_o;
        s_dl = dlast_o;
        s_by = busy_o;
        s_wc = words_cnt_o;
`ifdef FIFO_RD_TIMEOUT_EN
        s_err = rd_err_o;
`else
        s_err = 1'b0;
`endif
        if (s_dv) dv_cycles++;

        if (prev_stall) begin
            checks++;
            if (s_dv !== 1'b1 || s_d !== prev_dout) begin
                failures++;
                $display("FAIL stall_hold dvalid=%b dout=%h required dvalid=1 dout=%h",
                         s_dv, s_d, prev_dout);
            end
        end
        if (prev_rvalid) begin
            checks++;
            if (s_dv !== 1'b1) begin
                failures++;
                $display("FAIL rvalid_to_dvalid dvalid=%b required 1", s_dv);
            end
        end
        if (prev_last_req) begin
            checks++;
            if (s_rd !== 1'b1) begin
                failures++;
                $display("FAIL last_to_read fifo_read=%b required 1", s_rd);
            end
        end
        if (prev_done) begin
            checks++;
            if (s_wc !== 32'(exp_words)) begin
                failures++;
                $display("FAIL words_cnt got=%0d required=%0d", s_wc, exp_words);
            end
        end

        had_pend = (pend_cd >= 0);
        rv       = 1'b0;
        rv_data  = '0;
        if (pend_cd > 0) begin
            pend_cd--;
            if (pend_cd == 0) begin
                rv      = 1'b1;
                rv_data = pend_word;
                pend_cd = -1;
            end
        end

        if (s_rd) begin
            checks++;
            if (had_pend || fifo_q.size() == 0) begin
                failures++;
                $display("FAIL read_issue outstanding=%0d queued=%0d required outstanding=0 queued>0",
                         had_pend, fifo_q.size());
            end else begin
                pend_word = fifo_q.pop_front();
                exp_q.push_back(pend_word);
                pend_cd = (rv_delay > 0) ? rv_delay : int'($urandom_range(4, 1));
            end
        end

        stray = stray_en && !rv && !s_rd && (pend_cd < 0) && ($urandom_range(3, 0) == 0);

        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(1, 0));
            default: rdy = (s_dv && rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        endcase

        xfer      = s_dv && rdy;
        prev_done = 0;
        if (xfer) begin
            xfer_cnt++;
            beats_seen.push_back(s_d);
            xfer_cyc.push_back(cyc);
            acc = {acc[47:0], s_d};
            nb++;
            checks++;
            if (s_dl !== 1'(nb == 4)) begin
                failures++;
                $display("FAIL dlast beat=%0d dlast=%b required=%b", nb, s_dl, (nb == 4));
            end
            if (nb == 4) begin
                nb        = 0;
                exp_words++;
                prev_done = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL word_order got=%h required=<no word read>", acc);
                end else begin
                    w = exp_q.pop_front();
                    if (acc !== w) begin
                        failures++;
                        $display("FAIL word_order got=%h required=%h", acc, w);
                    end
                end
            end
        end

        prev_last_req = prev_done && (fifo_q.size() != 0);
        prev_stall    = s_dv && !rdy;
        prev_dout     = s_d;
        prev_rvalid   = rv;

        fifo_usedw_i  = (fifo_q.size() > 255) ? 8'hFF : 8'(fifo_q.size());
        fifo_rvalid_i = rv || stray;
        fifo_rdata_i  = rv ? rv_data : {$urandom, $urandom};
        dready_i      = rdy;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({fifo_read_o, dvalid_o, dlast_o, busy_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl read/dvalid/dlast/busy=%b required 0000",
                     {fifo_read_o, dvalid_o, dlast_o, busy_o});
        end
        checks++;
        if (dout_o !== 16'h0) begin
            failures++;
            $display("FAIL reset_dout got=%h required 0000", dout_o);
        end
        checks++;
        if (words_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_words got=%0d required 0", words_cnt_o);
        end
        reset = 1'b1;
    endtask

    task automatic test_empty();
        int rd_seen = 0, dv_seen = 0, by_seen = 0;
        rdy_mode = 1;
        stray_en = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (s_rd) rd_seen++;
            if (s_dv) dv_seen++;
            if (s_by) by_seen++;
        end
        stray_en = 0;
        checks++;
        if (rd_seen != 0) begin
            failures++;
            $display("FAIL empty_read read_cycles=%0d required 0", rd_seen);
        end
        checks++;
        if (dv_seen != 0) begin
            failures++;
            $display("FAIL empty_dvalid dvalid_cycles=%0d required 0", dv_seen);
        end
        checks++;
        if (by_seen != 0) begin
            failures++;
            $display("FAIL empty_busy busy_cycles=%0d required 0", by_seen);
        end
        checks++;
        if (s_wc !== 32'd0) begin
            failures++;
            $display("FAIL empty_words got=%0d required 0", s_wc);
        end
    endtask

    task automatic run_word(input int budget);
        xfer_cnt = 0;
        dv_cycles = 0;
        beats_seen.delete();
        xfer_cyc.delete();
        fifo_q.push_back(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < budget && xfer_cnt < 4; i++) step();
        repeat (10) step();
    endtask

    task automatic check_beats(input string name);
        logic [15:0] exp_b[4];
        exp_b = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        checks++;
        if (xfer_cnt != 4) begin
            failures++;
            $display("FAIL %s_xfers got=%0d required 4", name, xfer_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= beats_seen.size() || beats_seen[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL %s_beat%0d got=%h required=%h", name, i,
                         (i < beats_seen.size()) ? beats_seen[i] : 16'hxxxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_one_word();
        rv_delay = 2;
        rdy_mode = 0;
        run_word(60);
        check_beats("one_word");
        checks++;
        if (xfer_cyc.size() != 4 || xfer_cyc[3] - xfer_cyc[0] != 3) begin
            failures++;
            $display("FAIL one_word_consecutive span=%0d required 3",
                     (xfer_cyc.size() == 4) ? xfer_cyc[3] - xfer_cyc[0] : -1);
        end
        checks++;
        if (s_wc !== 32'd1) begin
            failures++;
            $display("FAIL one_word_count got=%0d required 1", s_wc);
        end
    endtask

    task automatic test_stall();
        rv_delay = 1;
        rdy_mode = 2;
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        run_word(60);
        check_beats("stall");
        checks++;
        if (dv_cycles != 7) begin
            failures++;
            $display("FAIL stall_dvalid_cycles got=%0d required 7", dv_cycles);
        end
        checks++;
        if (s_wc !== 32'd2) begin
            failures++;
            $display("FAIL stall_count got=%0d required 2", s_wc);
        end
    endtask

    task automatic test_random();
        int to_push = 300;
        int target  = exp_words + 300;
        rv_delay = 0;
        rdy_mode = 1;
        stray_en = 1;
        for (int i = 0; i < 30000 && exp_words < target; i++) begin
            if (to_push > 0 && fifo_q.size() < 200 && $urandom_range(2, 0) == 0) begin
                fifo_q.push_back({$urandom, $urandom});
                to_push--;
            end
            step();
        end
        repeat (5) step();
        stray_en = 0;
        checks++;
        if (s_wc !== 32'(target)) begin
            failures++;
            $display("FAIL random_words got=%0d required=%0d", s_wc, target);
        end
        checks++;
        if (exp_q.size() != 0 || fifo_q.size() != 0 || to_push != 0) begin
            failures++;
            $display("FAIL random_drain undelivered=%0d queued=%0d unpushed=%0d required 0/0/0",
                     exp_q.size(), fifo_q.size(), to_push);
        end
    endtask

    task automatic test_reset_mid_word();
        bit reached = 0;
        int dv_seen = 0, rd_seen = 0;
        rv_delay = 1;
        rdy_mode = 2;
        rdy_pat  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        xfer_cnt = 0;
        fifo_q.push_back({$urandom, $urandom});
        for (int i = 0; i < 40 && !reached; i++) begin
            step();
            reached = (xfer_cnt == 2) && s_dv && !dready_i;
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL midword_setup beat2_pending=0 required 1");
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({fifo_read_o, dvalid_o, dlast_o, busy_o} !== 4'b0000 || dout_o !== 16'h0 ||
            words_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL midword_reset read/dvalid/dlast/busy=%b dout=%h words=%0d required 0",
                     {fifo_read_o, dvalid_o, dlast_o, busy_o}, dout_o, words_cnt_o);
        end
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_dv) dv_seen++;
            if (s_rd) rd_seen++;
        end
        checks++;
        if (dv_seen != 0 || rd_seen != 0) begin
            failures++;
            $display("FAIL midword_after dvalid_cycles=%0d read_cycles=%0d required 0/0",
                     dv_seen, rd_seen);
        end
    endtask

`ifdef FIFO_RD_TIMEOUT_EN
    task automatic test_timeout();
        bit seen = 0;
        int wait_bad = 0, dv_seen = 0;
        reset_pulse();
        rv_delay = 1;
        rdy_mode = 0;
        fifo_q.push_back({$urandom, $urandom});
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = s_rd;
        end
        pend_cd = -1;
        exp_q.delete();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timeout_read fifo_read seen=0 required 1");
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_by !== 1'b1 || s_err !== 1'b0) wait_bad++;
        end
        checks++;
        if (wait_bad != 0) begin
            failures++;
            $display("FAIL timeout_wait bad_cycles=%0d required 0", wait_bad);
        end
        step();
        checks++;
        if (s_by !== 1'b0 || s_err !== 1'b1 || s_wc !== 32'd0) begin
            failures++;
            $display("FAIL timeout_expire busy=%b rd_err=%b words=%0d required 0/1/0",
                     s_by, s_err, s_wc);
        end
        stray_en = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_dv) dv_seen++;
        end
        stray_en = 0;
        checks++;
        if (dv_seen != 0 || s_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_late dvalid_cycles=%0d rd_err=%b required 0/1", dv_seen, s_err);
        end
    endtask
`endif

    initial begin
        model_clear();
        cyc = 0;
        test_reset();
        test_empty();
        test_one_word();
        test_stall();
        test_random();
        test_reset_mid_word();
`ifdef FIFO_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
